// File: rtl/iob_native_mem_resp.sv
// Native-interface single-port memory responder: byte-strobed writes,
// fixed read latency, and optional wait states after each write.
module iob_native_mem_resp #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned WR_WAIT  = 0
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                cke_i,
   input  logic                avalid_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rvalid_o,
   output logic                ready_o
);

   localparam int unsigned DEPTH  = 2**ADDR_W;
   localparam int unsigned NBYTES = DATA_W/8;
   localparam int unsigned CNT_W  = 3;
   localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'((READ_LAT > 1) ? READ_LAT - 2 : 32'd0);
   localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'((WR_WAIT > 0) ? WR_WAIT - 1 : 32'd0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } state_t;

   state_t                         state;
   logic [CNT_W-1:0]               cnt;
   logic [DATA_W-1:0]              mem [DEPTH];
   logic [READ_LAT-1:0]            pipe_vld;
   logic [READ_LAT-1:0][DATA_W-1:0] pipe_data;
   logic                           accept_c;
   logic                           wr_acc_c;
   logic                           rd_acc_c;

   // Handshake: only the idle state takes requests, and only while enabled.
   assign ready_o  = (state == ST_IDLE) && cke_i;
   assign accept_c = avalid_i && ready_o;
   assign wr_acc_c = accept_c && (wstrb_i != '0);
   assign rd_acc_c = accept_c && (wstrb_i == '0);

   // Busy sequencing: hold ready low for the read latency or write wait states.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (cke_i) begin
         unique case (state)
            ST_IDLE: begin
               if (wr_acc_c && (WR_WAIT > 0)) begin
                  state <= ST_WR_WAIT;
                  cnt   <= WR_CNT_INIT;
               end else if (rd_acc_c && (READ_LAT > 1)) begin
                  state <= ST_RD_WAIT;
                  cnt   <= RD_CNT_INIT;
               end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Read pipeline: data is sampled at acceptance so later writes cannot alter it;
   // each stage only reloads on a valid beat, so the last stage holds the previous response.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         pipe_vld  <= '0;
         pipe_data <= '0;
      end else if (cke_i) begin
         pipe_vld[0] <= rd_acc_c;
         if (rd_acc_c) begin
            pipe_data[0] <= mem[addr_i];
         end
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end
      end
   end

   assign rvalid_o = pipe_vld[READ_LAT-1];
   assign rdata_o  = pipe_data[READ_LAT-1];

   // Storage array: byte-masked writes, contents survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_acc_c) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_i[b]) begin
               mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// Bench for iob_native_mem_resp: three instances with different latency and
// write-wait settings, directed scenarios plus a randomized run against a reference model.
module tb_iob_native_mem_resp;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int NI = 3;

   logic          clk  = 1'b0;
   logic          arst = 1'b0;
   logic          cke    [NI];
   logic          avalid [NI];
   logic [AW-1:0] addr   [NI];
   logic [DW-1:0] wdata  [NI];
   logic [3:0]    wstrb  [NI];
   logic [DW-1:0] rdata  [NI];
   logic          rvalid [NI];
   logic          ready  [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   iob_native_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .WR_WAIT(0)) u_dut0 (
      .clk_i(clk), .arst_i(arst), .cke_i(cke[0]), .avalid_i(avalid[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]),
      .ready_o(ready[0]));

   iob_native_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .WR_WAIT(2)) u_dut1 (
      .clk_i(clk), .arst_i(arst), .cke_i(cke[1]), .avalid_i(avalid[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]),
      .ready_o(ready[1]));

   iob_native_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(4), .WR_WAIT(1)) u_dut2 (
      .clk_i(clk), .arst_i(arst), .cke_i(cke[2]), .avalid_i(avalid[2]), .addr_i(addr[2]),
      .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .rdata_o(rdata[2]), .rvalid_o(rvalid[2]),
      .ready_o(ready[2]));

   // Reference model: plain memory image, a busy-cycle count and one outstanding response.
   logic [DW-1:0] ref_mem [NI][1024];
   int            busy  [NI];
   bit            pv    [NI];
   int            prem  [NI];
   logic [DW-1:0] pdata [NI];
   bit            exp_rvalid [NI];
   logic [DW-1:0] exp_rdata  [NI];
   logic [DW-1:0] d_keep;

   function automatic int rl(input int k);
      case (k)
         0: return 3;
         1: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int ww(input int k);
      case (k)
         0: return 0;
         1: return 2;
         default: return 1;
      endcase
   endfunction

   function automatic bit exp_ready(input int k);
      return (busy[k] == 0) && (cke[k] === 1'b1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         busy[k] = 0; pv[k] = 0; prem[k] = 0; pdata[k] = '0;
         exp_rvalid[k] = 0; exp_rdata[k] = '0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         if (cke[k] === 1'b1) begin
            bit acc;
            acc = (avalid[k] === 1'b1) && (busy[k] == 0);
            if (pv[k] && prem[k] == 0) pv[k] = 0;
            else if (pv[k]) prem[k]--;
            if (acc && wstrb[k] != 4'h0) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[k][b]) ref_mem[k][addr[k]][b*8 +: 8] = wdata[k][b*8 +: 8];
               busy[k] = ww(k);
            end else if (acc) begin
               pv[k] = 1; prem[k] = rl(k) - 1; pdata[k] = ref_mem[k][addr[k]];
               busy[k] = rl(k) - 1;
            end else if (busy[k] > 0) begin
               busy[k]--;
            end
            exp_rvalid[k] = pv[k] && (prem[k] == 0);
            if (exp_rvalid[k]) exp_rdata[k] = pdata[k];
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < NI; k++) avalid[k] = 1'b0;
      repeat (n) tick();
   endtask

   // Issue one request on instance k, waiting (bounded) for acceptance.
   task automatic xfer(input int k, input int a, input logic [DW-1:0] d, input logic [3:0] s);
      bit done;
      done = 0;
      cke[k] = 1'b1; avalid[k] = 1'b1; addr[k] = AW'(a); wdata[k] = d; wstrb[k] = s;
      for (int t = 0; t < 20 && !done; t++) begin
         #1;
         if (ready[k] === 1'b1) done = 1;
         tick();
      end
      avalid[k] = 1'b0;
      n_tests++;
      if (!done) begin
         n_fail++; $display("FAIL xfer_timeout inst %0d addr %0d: never accepted", k, a);
      end
   endtask

   task automatic test_reset();
      #1 arst = 1'b1; model_reset(); cke[1] = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         n_tests++;
         if (ready[k] !== 1'(k != 1)) begin n_fail++; $display("FAIL reset_ready inst %0d: got %b exp %b", k, ready[k], k != 1); end
         n_tests++;
         if (rvalid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid inst %0d: got %b exp 0", k, rvalid[k]); end
         n_tests++;
         if (rdata[k] !== '0) begin n_fail++; $display("FAIL reset_rdata inst %0d: got %h exp 0", k, rdata[k]); end
      end
      cke[1] = 1'b1;
      #1;
      n_tests++;
      if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_cke inst 1: got %b exp 1", ready[1]); end
      arst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      avalid[0] = 1'b1; addr[0] = AW'(5); wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
      #1;
      n_tests++;
      if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL wr_rd_wr_ready: got %b exp 1", ready[0]); end
      tick();
      wstrb[0] = 4'h0; wdata[0] = '0;
      #1;
      n_tests++;
      if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rd_ready: got %b exp 1", ready[0]); end
      tick();
      avalid[0] = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         #1;
         n_tests++;
         if (ready[0] !== 1'(c >= 4)) begin n_fail++; $display("FAIL wr_rd_ready T+%0d: got %b exp %b", c, ready[0], c >= 4); end
         n_tests++;
         if (rvalid[0] !== 1'(c == 4)) begin n_fail++; $display("FAIL wr_rd_rvalid T+%0d: got %b exp %b", c, rvalid[0], c == 4); end
         if (c >= 4) begin
            n_tests++;
            if (rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_rdata T+%0d: got %h exp deadbeef", c, rdata[0]); end
         end
         tick();
      end
   endtask

   task automatic test_byte_strobe();
      int lat;
      xfer(0, 5, 32'h0000AA00, 4'b0010);
      avalid[0] = 1'b1; addr[0] = AW'(5); wstrb[0] = 4'h0;
      #1;
      n_tests++;
      if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL strb_ready: got %b exp 1", ready[0]); end
      tick();
      avalid[0] = 1'b0;
      lat = 1;
      while (rvalid[0] !== 1'b1 && lat < 10) begin tick(); lat++; end
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL strb_latency: got %0d exp 3", lat); end
      n_tests++;
      if (rdata[0] !== 32'hDEADAAEF) begin n_fail++; $display("FAIL strb_rdata: got %h exp deadaaef", rdata[0]); end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) xfer(1, i, DW'(i * 32'h11), 4'hF);
      idle(2);
      for (int i = 1; i <= 3; i++) begin
         avalid[1] = 1'b1; addr[1] = AW'(i); wstrb[1] = 4'h0;
         #1;
         n_tests++;
         if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready rd %0d: got %b exp 1", i, ready[1]); end
         tick();
         n_tests++;
         if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid rd %0d: got %b exp 1", i, rvalid[1]); end
         n_tests++;
         if (rdata[1] !== DW'(i * 32'h11)) begin n_fail++; $display("FAIL b2b_rdata rd %0d: got %h exp %h", i, rdata[1], i * 32'h11); end
      end
      avalid[1] = 1'b0;
      tick();
      n_tests++;
      if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_end: got %b exp 0", rvalid[1]); end
      n_tests++;
      if (rdata[1] !== 32'h33) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h exp 33", rdata[1]); end
   endtask

   task automatic test_wr_wait();
      logic [DW-1:0] d;
      d = $urandom;
      avalid[1] = 1'b1; addr[1] = AW'(7); wdata[1] = d; wstrb[1] = 4'hF;
      #1;
      n_tests++;
      if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL wrwait_accept: got %b exp 1", ready[1]); end
      tick();
      wstrb[1] = 4'h0;
      for (int c = 1; c <= 2; c++) begin
         #1;
         n_tests++;
         if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL wrwait_ready T+%0d: got %b exp 0", c, ready[1]); end
         n_tests++;
         if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL wrwait_rvalid T+%0d: got %b exp 0", c, rvalid[1]); end
         tick();
      end
      #1;
      n_tests++;
      if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL wrwait_ready T+3: got %b exp 1", ready[1]); end
      tick();
      avalid[1] = 1'b0;
      n_tests++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== d) begin n_fail++; $display("FAIL wrwait_readback: got %b/%h exp 1/%h", rvalid[1], rdata[1], d); end
   endtask

   task automatic test_cke_stall();
      d_keep = $urandom;
      xfer(2, 9, d_keep, 4'hF);
      idle(2);
      avalid[2] = 1'b1; addr[2] = AW'(9); wstrb[2] = 4'h0;
      #1;
      n_tests++;
      if (ready[2] !== 1'b1) begin n_fail++; $display("FAIL cke_accept: got %b exp 1", ready[2]); end
      tick();
      avalid[2] = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         cke[2] = (c <= 3) ? 1'b0 : 1'b1;
         #1;
         if (c <= 3) begin
            n_tests++;
            if (ready[2] !== 1'b0) begin n_fail++; $display("FAIL cke_ready T+%0d: got %b exp 0", c, ready[2]); end
         end
         n_tests++;
         if (rvalid[2] !== 1'(c == 7)) begin n_fail++; $display("FAIL cke_rvalid T+%0d: got %b exp %b", c, rvalid[2], c == 7); end
         if (c == 7) begin
            n_tests++;
            if (rdata[2] !== d_keep) begin n_fail++; $display("FAIL cke_rdata: got %h exp %h", rdata[2], d_keep); end
         end
         tick();
      end
      cke[2] = 1'b1;
   endtask

   task automatic test_reset_mid_read();
      int lat;
      avalid[2] = 1'b1; addr[2] = AW'(9); wstrb[2] = 4'h0;
      #1;
      tick();
      avalid[2] = 1'b0;
      tick();
      arst = 1'b1; model_reset();
      #1;
      n_tests++;
      if (rvalid[2] !== 1'b0 || rdata[2] !== '0 || ready[2] !== 1'b1) begin
         n_fail++; $display("FAIL rst_rd_outputs: got rv %b rd %h rdy %b exp 0/0/1", rvalid[2], rdata[2], ready[2]);
      end
      arst = 1'b0;
      #1;
      for (int c = 0; c < 8; c++) begin
         n_tests++;
         if (rvalid[2] !== 1'b0) begin n_fail++; $display("FAIL rst_rd_no_rvalid cyc %0d: got %b exp 0", c, rvalid[2]); end
         tick();
      end
      avalid[2] = 1'b1;
      #1;
      tick();
      avalid[2] = 1'b0;
      lat = 1;
      while (rvalid[2] !== 1'b1 && lat < 12) begin tick(); lat++; end
      n_tests++;
      if (lat != 4 || rdata[2] !== d_keep) begin n_fail++; $display("FAIL rst_rd_mem_kept: got lat %0d data %h exp 4/%h", lat, rdata[2], d_keep); end
      tick();
   endtask

   task automatic test_reset_mid_wr_wait();
      logic [DW-1:0] d;
      d = $urandom;
      avalid[1] = 1'b1; addr[1] = AW'(12); wdata[1] = d; wstrb[1] = 4'hF;
      #1;
      tick();
      avalid[1] = 1'b0;
      #1;
      n_tests++;
      if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL rst_wr_busy: got %b exp 0", ready[1]); end
      arst = 1'b1; model_reset();
      #1;
      n_tests++;
      if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b exp 1", ready[1]); end
      arst = 1'b0;
      avalid[1] = 1'b1; wstrb[1] = 4'h0;
      #1;
      tick();
      avalid[1] = 1'b0;
      n_tests++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== d) begin n_fail++; $display("FAIL rst_wr_committed: got %b/%h exp 1/%h", rvalid[1], rdata[1], d); end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 16; a++) xfer(k, a, DW'($urandom), 4'hF);
      idle(4);
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NI; k++) begin
            cke[k]    = ($urandom_range(9) != 0);
            avalid[k] = 1'($urandom_range(1));
            addr[k]   = AW'($urandom_range(15));
            wdata[k]  = DW'($urandom);
            wstrb[k]  = ($urandom_range(1) != 0) ? 4'($urandom_range(15)) : 4'h0;
         end
         #1;
         for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (ready[k] !== exp_ready(k)) begin n_fail++; $display("FAIL rand_ready inst %0d cyc %0d: got %b exp %b", k, n, ready[k], exp_ready(k)); end
         end
         tick();
         for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (rvalid[k] !== exp_rvalid[k]) begin n_fail++; $display("FAIL rand_rvalid inst %0d cyc %0d: got %b exp %b", k, n, rvalid[k], exp_rvalid[k]); end
            n_tests++;
            if (rdata[k] !== exp_rdata[k]) begin n_fail++; $display("FAIL rand_rdata inst %0d cyc %0d: got %h exp %h", k, n, rdata[k], exp_rdata[k]); end
         end
      end
      for (int k = 0; k < NI; k++) cke[k] = 1'b1;
      idle(6);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         cke[k] = 1'b1; avalid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = 4'h0;
      end
      d_keep = '0;
      model_reset();
      test_reset();
      test_write_read();
      test_byte_strobe();
      test_back_to_back();
      test_wr_wait();
      test_cke_stall();
      test_reset_mid_read();
      test_reset_mid_wr_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
